mul_div_unit: RTL

Iterative, parametrised multiply/divide unit with architectural HI/LO registers. It is the sequential companion to the single-cycle ALU and sits beside it in the execute stage. The pipeline issues one operation with a start pulse and stalls on `busy`. Results land in HI/LO and are read out combinationally through the `hi`/`lo` ports.

---
 rtl/mdu_pkg.sv | 25 ++
 rtl/mdu_cneg.sv | 19 +
 rtl/mul_div_unit.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mdu_pkg
// Brief    : Shared op-code and state encodings for the multiply/divide unit.
// Revision : 1.0 - initial release
// ============================================================================
package mdu_pkg;

    // Operation codes issued by the execute stage
    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    // Iteration state machine
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mdu_cneg.sv
`default_nettype none
// ============================================================================
// Module   : mdu_cneg
// Brief    : Conditional two's-complement negate (res = neg ? -val : val).
// Revision : 1.0 - initial release
// ============================================================================
module mdu_cneg #(
    parameter int W = 32
) (
    input  logic [W-1:0] val_i,
    input  logic         neg_i,
    output logic [W-1:0] res_o
);

    // Invert and add one when negation is requested; pass through otherwise
    assign res_o = neg_i ? ((~val_i) + W'(1)) : val_i;

endmodule
`default_nettype wire

// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : mul_div_unit
// Brief    : Iterative shift-add multiplier / restoring divider with HI/LO
//            architectural registers. One result bit per RUN cycle, one FIX
//            cycle for sign correction and write-back.
// Revision : 1.0 - initial release
// ============================================================================
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int             CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t             state_q;
    logic [CW-1:0]      cnt_q;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               done_q;
    logic [WIDTH-1:0]   work_hi_q;   // product high half / partial remainder
    logic [WIDTH-1:0]   work_lo_q;   // multiplier bits / dividend -> quotient
    logic [WIDTH-1:0]   opb_q;       // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   a_raw_q;     // dividend as presented, for divide-by-zero
    logic               is_div_q;
    logic               neg_res_q;   // product / quotient sign
    logic               neg_rem_q;   // remainder sign follows the dividend
    logic               div0_q;

    // ------------------------------------------------------------------
    // Operand conditioning at acceptance
    // ------------------------------------------------------------------
    logic               accept;
    logic               op_signed;
    logic               sign_a, sign_b;
    logic [WIDTH-1:0]   abs_a, abs_b;

    assign accept    = start && !flush && (state_q == S_IDLE);
    assign op_signed = (op == OP_MULT) || (op == OP_DIV);
    assign sign_a    = op_signed && a[WIDTH-1];
    assign sign_b    = op_signed && b[WIDTH-1];

    mdu_cneg #(.W(WIDTH)) u_abs_a (.val_i(a), .neg_i(sign_a), .res_o(abs_a));
    mdu_cneg #(.W(WIDTH)) u_abs_b (.val_i(b), .neg_i(sign_b), .res_o(abs_b));

    // ------------------------------------------------------------------
    // One iteration step of multiply or divide
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]   mul_addend;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;   // WIDTH+1-bit partial remainder
    logic               div_ge;
    logic [WIDTH-1:0]   div_diff;
    logic [WIDTH-1:0]   work_hi_d, work_lo_d;

    assign mul_addend = work_lo_q[0] ? opb_q : '0;

    // Shift-add multiply step or restoring divide step, selected by op kind
    always_comb begin
        mul_sum   = {1'b0, work_hi_q} + {1'b0, mul_addend};
        div_shift = {work_hi_q, work_lo_q[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, opb_q});
        // Remainder stays below the divisor, so the difference fits WIDTH bits
        div_diff  = div_shift[WIDTH-1:0] - opb_q;
        work_hi_d = mul_sum[WIDTH:1];
        work_lo_d = {mul_sum[0], work_lo_q[WIDTH-1:1]};
        if (is_div_q) begin
            work_hi_d = div_ge ? div_diff : div_shift[WIDTH-1:0];
            work_lo_d = {work_lo_q[WIDTH-2:0], div_ge};
        end
    end

    // ------------------------------------------------------------------
    // Sign fix-up and result selection for the FIX cycle
    // ------------------------------------------------------------------
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix;
    logic [WIDTH-1:0]   res_hi_d, res_lo_d;

    mdu_cneg #(.W(2*WIDTH)) u_fix_prod (
        .val_i({work_hi_q, work_lo_q}), .neg_i(neg_res_q), .res_o(prod_fix));
    mdu_cneg #(.W(WIDTH)) u_fix_quot (
        .val_i(work_lo_q), .neg_i(neg_res_q), .res_o(quot_fix));
    mdu_cneg #(.W(WIDTH)) u_fix_rem (
        .val_i(work_hi_q), .neg_i(neg_rem_q), .res_o(rem_fix));

    // Pick product halves, quotient/remainder, or the divide-by-zero pattern
    always_comb begin
        res_hi_d = prod_fix[2*WIDTH-1:WIDTH];
        res_lo_d = prod_fix[WIDTH-1:0];
        if (is_div_q) begin
            if (div0_q) begin
                res_hi_d = a_raw_q;
                res_lo_d = '1;
            end else begin
                res_hi_d = rem_fix;
                res_lo_d = quot_fix;
            end
        end
    end

    // FSM, iteration counter, datapath and HI/LO registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            work_hi_q <= '0;
            work_lo_q <= '0;
            opb_q     <= '0;
            a_raw_q   <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        case (op)
                            OP_MTHI: hi_q <= a;
                            OP_MTLO: lo_q <= a;
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                state_q   <= S_RUN;
                                cnt_q     <= CNT_LAST;
                                work_hi_q <= '0;
                                work_lo_q <= abs_a;
                                opb_q     <= abs_b;
                                a_raw_q   <= a;
                                is_div_q  <= (op == OP_DIV) || (op == OP_DIVU);
                                neg_res_q <= sign_a ^ sign_b;
                                neg_rem_q <= sign_a;
                                div0_q    <= (b == '0);
                            end
                            default: ;
                        endcase
                    end
                end
                S_RUN: begin
                    if (flush) begin
                        state_q <= S_IDLE;
                    end else begin
                        work_hi_q <= work_hi_d;
                        work_lo_q <= work_lo_d;
                        if (cnt_q == '0) begin
                            state_q <= S_FIX;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                end
                S_FIX: begin
                    state_q <= S_IDLE;
                    if (!flush) begin
                        hi_q   <= res_hi_d;
                        lo_q   <= res_lo_d;
                        done_q <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
`default_nettype wire
